// File: rtl/credit_counter.sv
// Coin/credit accounting: synchronised + debounced switches, saturating credit count, start pulse FSM.
// Optional coin meter drive enabled by defining CREDIT_METER_EN.
module credit_counter #(
  parameter int unsigned DEBOUNCE_CYCLES    = 65536,
  parameter int unsigned CREDIT_MAX         = 15,
  parameter int unsigned START_PULSE_CYCLES = 1024,
  parameter int unsigned METER_CYCLES       = 2097152
) (
  input  logic       CLK_DRV,
  input  logic       RESET_N,
  input  logic       COIN1_N,
  input  logic       COIN2_N,
  input  logic       START1_N,
  input  logic       START2_N,
  input  logic       BONUS_COIN,
  input  logic       ATTRACT_N,
  input  logic       COIN_MODE,
  output logic [3:0] CREDIT,
  output logic       CREDIT_LAMP1,
  output logic       CREDIT_LAMP2,
  output logic       START_GAME1_N,
  output logic       PLAYERS2,
  output logic       COIN_METER
);

  localparam int unsigned NSW   = 4;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SP_W  = $clog2(START_PULSE_CYCLES + 1);
  localparam int unsigned NET_W = 6;
  localparam logic signed [NET_W-1:0] NET_MAX = NET_W'(CREDIT_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD} st_e;

  logic [NSW-1:0]  sw_raw, sw_s1, sw_s2, sw_acc, sw_acc_d, sw_fall;
  logic [DB_W-1:0] db_cnt [NSW];
  logic [1:0]      ctl_s1, ctl_s2;
  logic            bonus_d, bonus_ev, attr_s;
  logic            c1_ev, c2_ev, s1_ev, s2_ev;
  logic [1:0]      coin_cnt, credited, cost;
  logic [2:0]      half_sum;
  logic            half, half_nxt, take1, take2, start_ok;
  logic signed [NET_W-1:0] net;
  logic [3:0]      credit_nxt;
  st_e             st, st_nxt;
  logic [SP_W-1:0] sp_cnt, sp_cnt_nxt;

  assign sw_raw = {START2_N, START1_N, COIN2_N, COIN1_N};

  // Two-flop synchronisers; switches idle high, bonus/attract flops clear to 0
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_s1   <= '1;
      sw_s2   <= '1;
      ctl_s1  <= '0;
      ctl_s2  <= '0;
      bonus_d <= 1'b0;
    end else begin
      sw_s1   <= sw_raw;
      sw_s2   <= sw_s1;
      ctl_s1  <= {ATTRACT_N, BONUS_COIN};
      ctl_s2  <= ctl_s1;
      bonus_d <= ctl_s2[0];
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_acc   <= '1;
      sw_acc_d <= '1;
      for (int i = 0; i < NSW; i++) db_cnt[i] <= '0;
    end else begin
      sw_acc_d <= sw_acc;
      for (int i = 0; i < NSW; i++) begin
        if (sw_s2[i] != sw_acc[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            sw_acc[i] <= sw_s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign sw_fall  = sw_acc_d & ~sw_acc;
  assign c1_ev    = sw_fall[0];
  assign c2_ev    = sw_fall[1];
  assign s1_ev    = sw_fall[2];
  assign s2_ev    = sw_fall[3];
  assign bonus_ev = ctl_s2[0] & ~bonus_d;
  assign attr_s   = ctl_s2[1];

  // Same-cycle credit arithmetic; start eligibility is judged on the pre-update count
  always_comb begin
    coin_cnt = {1'b0, c1_ev} + {1'b0, c2_ev};
    half_sum = {1'b0, coin_cnt} + {2'b00, half};
    if (COIN_MODE) begin
      credited = half_sum[2:1];
      half_nxt = half_sum[0];
    end else begin
      credited = coin_cnt;
      half_nxt = half;
    end
    start_ok = ~attr_s & (st == ST_IDLE);
    take2    = start_ok & s2_ev & (CREDIT >= 4'd2);
    take1    = start_ok & ~take2 & s1_ev & (CREDIT >= 4'd1);
    cost     = take2 ? 2'd2 : (take1 ? 2'd1 : 2'd0);
    net      = $signed({2'b00, CREDIT}) + $signed({4'b0000, credited})
             + $signed({5'b00000, bonus_ev}) - $signed({4'b0000, cost});
    if (net < 0)             credit_nxt = 4'd0;
    else if (net > NET_MAX)  credit_nxt = 4'(CREDIT_MAX);
    else                     credit_nxt = net[3:0];
  end

  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      CREDIT   <= 4'd0;
      half     <= 1'b0;
      PLAYERS2 <= 1'b0;
    end else begin
      CREDIT <= credit_nxt;
      half   <= half_nxt;
      if (take2)      PLAYERS2 <= 1'b1;
      else if (take1) PLAYERS2 <= 1'b0;
    end
  end

  assign CREDIT_LAMP1 = (CREDIT >= 4'd1) & ~attr_s;
  assign CREDIT_LAMP2 = (CREDIT >= 4'd2) & ~attr_s;

  // Start FSM: state register
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      st     <= ST_IDLE;
      sp_cnt <= '0;
    end else begin
      st     <= st_nxt;
      sp_cnt <= sp_cnt_nxt;
    end
  end

  // Start FSM: next state; HOLD waits for the game to leave attract mode
  always_comb begin
    st_nxt     = st;
    sp_cnt_nxt = sp_cnt;
    case (st)
      ST_IDLE: begin
        if (take1 | take2) begin
          st_nxt     = ST_PULSE;
          sp_cnt_nxt = SP_W'(START_PULSE_CYCLES - 1);
        end
      end
      ST_PULSE: begin
        if (sp_cnt == '0) st_nxt = ST_HOLD;
        else              sp_cnt_nxt = sp_cnt - SP_W'(1);
      end
      ST_HOLD: begin
        if (attr_s) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Start FSM: outputs (decoded from the state register, so glitch-free and async-reset high)
  always_comb begin
    START_GAME1_N = 1'b1;
    if (st == ST_PULSE) START_GAME1_N = 1'b0;
  end

`ifdef CREDIT_METER_EN
  localparam int unsigned MT_W = $clog2(METER_CYCLES + 1);

  typedef enum logic [1:0] {MT_IDLE, MT_HIGH, MT_LOW} mt_e;

  mt_e             mt_st, mt_nxt;
  logic [MT_W-1:0] mt_cnt, mt_cnt_nxt;
  logic [2:0]      pend, pend_nxt;
  logic [3:0]      pend_sum;
  logic            mt_dec;

  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      mt_st  <= MT_IDLE;
      mt_cnt <= '0;
      pend   <= 3'd0;
    end else begin
      mt_st  <= mt_nxt;
      mt_cnt <= mt_cnt_nxt;
      pend   <= pend_nxt;
    end
  end

  // Every coin event (before halving) is metered; one pending count retires per high/low pair
  always_comb begin
    mt_nxt     = mt_st;
    mt_cnt_nxt = mt_cnt;
    mt_dec     = (mt_st == MT_LOW) && (mt_cnt == '0);
    pend_sum   = {1'b0, pend} + {2'b00, coin_cnt} - {3'b000, mt_dec};
    pend_nxt   = (pend_sum > 4'd7) ? 3'd7 : pend_sum[2:0];
    case (mt_st)
      MT_IDLE: begin
        if (pend != 3'd0) begin
          mt_nxt     = MT_HIGH;
          mt_cnt_nxt = MT_W'(METER_CYCLES - 1);
        end
      end
      MT_HIGH: begin
        if (mt_cnt == '0) begin
          mt_nxt     = MT_LOW;
          mt_cnt_nxt = MT_W'(METER_CYCLES - 1);
        end else begin
          mt_cnt_nxt = mt_cnt - MT_W'(1);
        end
      end
      MT_LOW: begin
        if (mt_cnt == '0) begin
          if (pend_nxt != 3'd0) begin
            mt_nxt     = MT_HIGH;
            mt_cnt_nxt = MT_W'(METER_CYCLES - 1);
          end else begin
            mt_nxt = MT_IDLE;
          end
        end else begin
          mt_cnt_nxt = mt_cnt - MT_W'(1);
        end
      end
      default: mt_nxt = MT_IDLE;
    endcase
  end

  always_comb begin
    COIN_METER = 1'b0;
    if (mt_st == MT_HIGH) COIN_METER = 1'b1;
  end
`else
  assign COIN_METER = 1'b0;
`endif

endmodule
